// File: rtl/fb_pkg.sv
// Shared constants and state type for the ping-pong frame buffer scheduler.
package fb_pkg;
    localparam int FB_ADDR_W    = 15;
    localparam int PIX_W        = 2;
    localparam int FRAME_PIXELS = 23040;
    localparam int LAST_PIX     = FRAME_PIXELS - 1;
    localparam int DROP_W       = 8;

    typedef enum logic {
        ST_EMPTY,
        ST_READY
    } fbState_t;
endpackage

// File: rtl/fb_bank_ctrl.sv
// Bank bookkeeping: capture sync flag, write/read bank bits, EMPTY/READY
// hand-off FSM and the saturating dropped-frame counter.
module fb_bank_ctrl
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_syncHit,
    input  logic              i_frameEnd,
    input  logic              i_frameRelease,
    output logic              o_synced,
    output logic              o_wbank,
    output logic              o_rbank,
    output logic              o_ready,
    output logic [DROP_W-1:0] o_framesDropped
);
    fbState_t          r_state;
    fbState_t          w_nextState;
    logic              w_swap;
    logic              w_drop;
    logic              r_synced;
    logic              r_wbank;
    logic              r_rbank;
    logic [DROP_W-1:0] r_drops;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_EMPTY: if (i_frameEnd) w_nextState = ST_READY;
            ST_READY: if (i_frameRelease && !i_frameEnd) w_nextState = ST_EMPTY;
            default:  w_nextState = ST_EMPTY;
        endcase
    end

    // A finished frame is published unless the reader still holds the other bank.
    always_comb begin
        o_ready = (r_state == ST_READY);
        w_swap  = i_frameEnd && ((r_state == ST_EMPTY) || i_frameRelease);
        w_drop  = i_frameEnd && (r_state == ST_READY) && !i_frameRelease;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_synced <= 1'b0;
            r_wbank  <= 1'b0;
            r_rbank  <= 1'b1;
            r_drops  <= '0;
        end else begin
            if (i_syncHit) r_synced <= 1'b1;
            if (w_swap) begin
                r_rbank <= r_wbank;
                r_wbank <= ~r_wbank;
            end
            if (w_drop && (r_drops != {DROP_W{1'b1}})) r_drops <= r_drops + 1'b1;
        end
    end

    assign o_synced        = r_synced;
    assign o_wbank         = r_wbank;
    assign o_rbank         = r_rbank;
    assign o_framesDropped = r_drops;
endmodule

// File: rtl/fb_bank_scheduler.sv
// Shares a 2-bank single-port frame RAM between the capture writer (priority)
// and the AI frame reader, which only sees complete frames.
module fb_bank_scheduler
    import fb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cap_valid,
    input  logic [FB_ADDR_W-1:0] cap_addr,
    input  logic [PIX_W-1:0]     cap_data,
    input  logic                 rd_req,
    input  logic [FB_ADDR_W-1:0] rd_addr,
    output logic                 rd_gnt,
    output logic                 rd_valid,
    output logic [PIX_W-1:0]     rd_data,
    output logic                 frame_ready,
    input  logic                 frame_release,
    output logic [DROP_W-1:0]    frames_dropped,
    output logic [FB_ADDR_W:0]   ram_addr,
    output logic                 ram_we,
    output logic [PIX_W-1:0]     ram_wdata,
    input  logic [PIX_W-1:0]     ram_rdata
);
    logic w_inRange;
    logic w_addrZero;
    logic w_syncHit;
    logic w_capWrite;
    logic w_frameEnd;
    logic w_synced;
    logic w_wbank;
    logic w_rbank;
    logic w_ready;
    logic r_rdValid;

    // Pixel 0 both starts a frame and establishes sync, so it is written even when unsynced.
    assign w_inRange  = (cap_addr < FB_ADDR_W'(FRAME_PIXELS));
    assign w_addrZero = (cap_addr == '0);
    assign w_syncHit  = cap_valid && w_inRange && w_addrZero;
    assign w_capWrite = cap_valid && w_inRange && (w_synced || w_addrZero);
    assign w_frameEnd = w_capWrite && (cap_addr == FB_ADDR_W'(LAST_PIX));

    fb_bank_ctrl u_bankCtrl (
        .clk             (clk),
        .rst             (rst),
        .i_syncHit       (w_syncHit),
        .i_frameEnd      (w_frameEnd),
        .i_frameRelease  (frame_release),
        .o_synced        (w_synced),
        .o_wbank         (w_wbank),
        .o_rbank         (w_rbank),
        .o_ready         (w_ready),
        .o_framesDropped (frames_dropped)
    );

    assign rd_gnt    = !w_capWrite && rd_req && w_ready;
    assign ram_we    = w_capWrite;
    assign ram_wdata = cap_data;
    assign ram_addr  = w_capWrite ? {w_wbank, cap_addr} : {w_rbank, rd_addr};

    always_ff @(posedge clk) begin
        if (rst) r_rdValid <= 1'b0;
        else     r_rdValid <= rd_gnt;
    end

    assign rd_valid    = r_rdValid;
    assign rd_data     = r_rdValid ? ram_rdata : '0;
    assign frame_ready = w_ready;
endmodule

// File: tb/tb_fb_bank_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a frame-level behavioural model of the scheduler.
module tb_fb_bank_scheduler;
   localparam int FP   = 160 * 144;
   localparam int LAST = FP - 1;

   logic        clk;
   logic        rst;
   logic        capValid;
   logic [14:0] capAddr;
   logic [1:0]  capData;
   logic        rdReq;
   logic [14:0] rdAddr;
   logic        rdGnt;
   logic        rdValid;
   logic [1:0]  rdData;
   logic        frameReady;
   logic        frameRelease;
   logic [7:0]  framesDropped;
   logic [15:0] ramAddr;
   logic        ramWe;
   logic [1:0]  ramWdata;
   logic [1:0]  ramRdata;

   int checks;
   int failures;

   logic [1:0] ramMem [0:65535];
   logic [1:0] mdlMem [0:1][0:32767];

   bit       mdlLive;
   bit       mSynced;
   bit       mWbank;
   bit       mRbank;
   bit       mReady;
   int       mDrops;
   bit       pendValid;
   bit [1:0] pendData;
   bit [1:0] pix7;

   fb_bank_scheduler dut (
      .clk            (clk),
      .rst            (rst),
      .cap_valid      (capValid),
      .cap_addr       (capAddr),
      .cap_data       (capData),
      .rd_req         (rdReq),
      .rd_addr        (rdAddr),
      .rd_gnt         (rdGnt),
      .rd_valid       (rdValid),
      .rd_data        (rdData),
      .frame_ready    (frameReady),
      .frame_release  (frameRelease),
      .frames_dropped (framesDropped),
      .ram_addr       (ramAddr),
      .ram_we         (ramWe),
      .ram_wdata      (ramWdata),
      .ram_rdata      (ramRdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM with one cycle read latency.
   always @(posedge clk) begin
      if (ramWe) ramMem[ramAddr] <= ramWdata;
      ramRdata <= ramMem[ramAddr];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Outputs are compared mid-cycle; the model then advances to its state after the next edge.
   always @(negedge clk) begin
      bit expWrite;
      bit expGnt;
      bit frameEnd;
      expWrite = capValid && (int'(capAddr) < FP) && (mSynced || capAddr == 0);
      expGnt   = !expWrite && rdReq && mReady;
      if (mdlLive) begin
         checkOutput("ram_we", ramWe, expWrite);
         checkOutput("rd_gnt", rdGnt, expGnt);
         if (expWrite) begin
            checkOutput("wr_addr", ramAddr, {mWbank, capAddr});
            checkOutput("wr_data", ramWdata, capData);
         end
         if (expGnt) checkOutput("rd_addr", ramAddr, {mRbank, rdAddr});
         checkOutput("rd_valid", rdValid, pendValid);
         checkOutput("rd_data", rdData, pendValid ? pendData : 2'b00);
         checkOutput("frame_ready", frameReady, mReady);
         checkOutput("frames_dropped", framesDropped, mDrops);
      end
      if (rst) begin
         mdlLive   = 1'b1;
         mSynced   = 1'b0;
         mWbank    = 1'b0;
         mRbank    = 1'b1;
         mReady    = 1'b0;
         mDrops    = 0;
         pendValid = 1'b0;
         pendData  = 2'b00;
      end else if (mdlLive) begin
         if (expWrite) mdlMem[mWbank][capAddr] = capData;
         pendValid = expGnt;
         pendData  = mdlMem[mRbank][rdAddr];
         frameEnd  = expWrite && (int'(capAddr) == LAST);
         if (capValid && capAddr == 0) mSynced = 1'b1;
         if (frameEnd && (!mReady || frameRelease)) begin
            mRbank = mWbank;
            mWbank = !mWbank;
            mReady = 1'b1;
         end else if (frameEnd) begin
            if (mDrops < 255) mDrops++;
         end else if (mReady && frameRelease) begin
            mReady = 1'b0;
         end
      end
   end

   task automatic applyStimulus(input bit cv, input int ca, input int cd, input bit rr,
                                input int ra, input bit rel, input bit rs);
      capValid     = cv;
      capAddr      = 15'(ca);
      capData      = 2'(cd);
      rdReq        = rr;
      rdAddr       = 15'(ra);
      frameRelease = rel;
      rst          = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int a;
      int d;
      bit lastCap;
      for (int i = 0; i < 65536; i++) ramMem[i] = 2'b00;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 32768; i++) mdlMem[b][i] = 2'b00;
      ramRdata = 2'b00;
      checks   = 0;
      failures = 0;
      mdlLive  = 1'b0;
      capValid = 0; capAddr = 0; capData = 0; rdReq = 0; rdAddr = 0; frameRelease = 0; rst = 1;

      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
      idle(2);
      checkOutput("reset_frame_ready", frameReady, 0);
      checkOutput("reset_frames_dropped", framesDropped, 0);
      checkOutput("reset_rd_valid", rdValid, 0);
      checkOutput("reset_rd_data", rdData, 0);

      // Capture joins mid-frame: nothing may be written before pixel 0.
      for (int i = 100; i < 110; i++) begin
         capValid = 1; capAddr = 15'(i); #1;
         checkOutput("presync_we", ramWe, 0);
         @(posedge clk); #1;
         idle(1);
      end
      capValid = 1; capAddr = 15'(LAST); #1;
      checkOutput("presync_last_we", ramWe, 0);
      @(posedge clk); #1;
      idle(2);
      checkOutput("presync_frame_ready", frameReady, 0);

      // One complete frame, a pixel every second cycle.
      for (a = 0; a < FP; a++) begin
         d = $urandom_range(0, 3);
         if (a == 7) pix7 = 2'(d);
         applyStimulus(1, a, d, 0, 0, 0, 0);
         applyStimulus(0, 0, 0, 0, 0, 0, 0);
      end
      checkOutput("full_frame_ready", frameReady, 1);
      rdReq = 1; rdAddr = 15'd7; #1;
      checkOutput("first_read_gnt", rdGnt, 1);
      checkOutput("first_read_rbank", ramAddr[15], 0);
      @(posedge clk); #1;
      checkOutput("first_read_valid", rdValid, 1);
      checkOutput("first_read_pix7", rdData, pix7);

      // Second frame with reads requested every cycle; frame is dropped at its end.
      capValid = 1; capAddr = 0; capData = 2'($urandom_range(0, 3)); #1;
      checkOutput("write_beats_read", rdGnt, 0);
      checkOutput("second_frame_wbank", ramAddr[15], 1);
      @(posedge clk); #1;
      applyStimulus(0, 0, 0, 1, $urandom_range(0, LAST), 0, 0);
      for (int k = 0; k < 200; k++) begin
         a = (k == 199) ? LAST : $urandom_range(1, LAST - 1);
         applyStimulus(1, a, $urandom_range(0, 3), 1, $urandom_range(0, LAST), 0, 0);
         applyStimulus(0, 0, 0, 1, $urandom_range(0, LAST), 0, 0);
      end
      checkOutput("drop_frame_ready", frameReady, 1);
      checkOutput("drop_count", framesDropped, 1);
      for (int k = 0; k < 50; k++) applyStimulus(0, 0, 0, 1, $urandom_range(0, LAST), 0, 0);
      applyStimulus(0, 0, 0, 1, 7, 0, 0);
      checkOutput("held_frame_pix7", rdData, pix7);

      // Third frame ends in the same cycle the reader releases: swap without a drop.
      applyStimulus(1, 0, 1, 0, 0, 0, 0);
      idle(1);
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1, $urandom_range(1, LAST - 1), $urandom_range(0, 3), 0, 0, 0, 0);
         idle(1);
      end
      applyStimulus(1, LAST, 2, 0, 0, 1, 0);
      idle(1);
      checkOutput("release_swap_ready", frameReady, 1);
      checkOutput("release_swap_drops", framesDropped, 1);
      rdReq = 1; rdAddr = 15'd3; #1;
      checkOutput("release_swap_rbank", ramAddr[15], 1);
      @(posedge clk); #1;

      // Reset lands on a granted read mid-frame.
      applyStimulus(1, 0, 3, 0, 0, 0, 0);
      idle(1);
      applyStimulus(1, 1, 3, 0, 0, 0, 0);
      capValid = 0; rdReq = 1; rdAddr = 15'd9; rst = 1; #1;
      checkOutput("pre_reset_gnt", rdGnt, 1);
      @(posedge clk); #1;
      rst = 0; rdReq = 0;
      checkOutput("squash_rd_valid", rdValid, 0);
      checkOutput("reset_mid_frame_ready", frameReady, 0);
      capValid = 1; capAddr = 15'd5; #1;
      checkOutput("resync_needed_we", ramWe, 0);
      @(posedge clk); #1;
      idle(1);
      capValid = 1; capAddr = 0; capData = 2'd1; #1;
      checkOutput("resync_we", ramWe, 1);
      checkOutput("resync_wbank", ramAddr[15], 0);
      @(posedge clk); #1;
      idle(1);

      // Random traffic with sparse frames, stray addresses, releases and resets.
      lastCap = 0;
      for (int k = 0; k < 4000; k++) begin
         bit cv;
         int sel;
         cv  = lastCap ? 1'b0 : 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 9);
         case (sel)
            0:       a = 0;
            1, 2:    a = LAST;
            3:       a = FP + $urandom_range(0, 9000);
            default: a = $urandom_range(0, LAST);
         endcase
         applyStimulus(cv, a, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                       $urandom_range(0, LAST), $urandom_range(0, 7) == 0,
                       $urandom_range(0, 499) == 0);
         lastCap = cv;
      end
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
